// File: rtl/locker_pkg.sv
// Shared state encodings and width helpers for the locker controller.
package locker_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_GRANTED = 2'd1;
    localparam logic [1:0] ST_LOCKOUT = 2'd2;

    function automatic int user_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int fail_w(input int m);
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

    function automatic int tmr_w(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/locker_timer.sv
// Loadable down-counter shared by the access window and the lockout period.
module locker_timer #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] value_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q, cnt_d;

    // Load wins over decrement; the counter parks at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = value_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/locker_ctrl.sv
// Multi-user locker controller: password check/reprogram, per-user failure count, timed access and lockout.
// Optional master key enabled by defining LOCKER_MASTER_KEY_EN.
module locker_ctrl
    import locker_pkg::*;
#(
    parameter int                        NUM_USERS  = 4,
    parameter int                        PW_W       = 12,
    parameter logic [NUM_USERS*PW_W-1:0] DEFAULT_PW = {12'h999, 12'hECE, 12'h0AA, 12'hF2A},
    parameter int                        MAX_FAIL   = 3,
    parameter int                        ACCESS_CYC = 256,
    parameter int                        LOCK_CYC   = 1024,
    parameter logic [PW_W-1:0]           MASTER_PW  = 12'h000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enter_i,
    input  logic                          set_mode_i,
    input  logic [user_w(NUM_USERS)-1:0]  user_i,
    input  logic [PW_W-1:0]               pw_in_i,
    input  logic [PW_W-1:0]               new_pw_i,
    output logic                          access_o,
    output logic                          alarm_o,
    output logic                          locked_o,
    output logic [fail_w(MAX_FAIL)-1:0]   fail_cnt_o,
    output logic                          set_ok_o
);

    localparam int UW = user_w(NUM_USERS);
    localparam int FW = fail_w(MAX_FAIL);
    localparam int TW = tmr_w(ACCESS_CYC, LOCK_CYC);

    localparam logic [FW-1:0] FAIL_MAX  = FW'(MAX_FAIL);
    localparam logic [TW-1:0] ACCESS_LD = TW'(ACCESS_CYC - 1);
    localparam logic [TW-1:0] LOCK_LD   = TW'(LOCK_CYC - 1);

`ifdef LOCKER_MASTER_KEY_EN
    localparam bit MASTER_KEY_EN = 1'b1;
`else
    localparam bit MASTER_KEY_EN = 1'b0;
`endif

    logic [PW_W-1:0] pass_q [NUM_USERS];
    logic [PW_W-1:0] pass_d [NUM_USERS];
    logic [FW-1:0]   fail_q [NUM_USERS];
    logic [FW-1:0]   fail_d [NUM_USERS];
    logic [1:0]      state_q, state_d;
    logic [UW-1:0]   lock_user_q, lock_user_d;
    logic            access_q, alarm_q, locked_q, set_ok_q;
    logic            set_ok_d;

    logic            tmr_load, tmr_dec, tmr_zero;
    logic [TW-1:0]   tmr_val;

    logic            user_valid;
    logic [PW_W-1:0] sel_pw;
    logic [FW-1:0]   sel_fail;
    logic [FW-1:0]   fail_inc;
    logic            pw_match;
    logic            cmd_ok;
    logic            master_hit;

    locker_timer #(
        .W (TW)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .load_i  (tmr_load),
        .value_i (tmr_val),
        .dec_i   (tmr_dec),
        .zero_o  (tmr_zero)
    );

    // Select the addressed user's password and counter; out-of-range users read as invalid.
    always_comb begin
        user_valid = 1'b0;
        sel_pw     = '0;
        sel_fail   = '0;
        for (int i = 0; i < NUM_USERS; i++) begin
            if (user_i == UW'(i)) begin
                user_valid = 1'b1;
                sel_pw     = pass_q[i];
                sel_fail   = fail_q[i];
            end
        end
    end

    assign pw_match   = user_valid && (pw_in_i == sel_pw);
    assign fail_inc   = (sel_fail == FAIL_MAX) ? sel_fail : sel_fail + FW'(1);
    assign cmd_ok     = enter_i && (state_q != ST_LOCKOUT);
    assign master_hit = MASTER_KEY_EN && enter_i && !set_mode_i && (pw_in_i == MASTER_PW);
    assign fail_cnt_o = sel_fail;

    always_comb begin
        state_d     = state_q;
        pass_d      = pass_q;
        fail_d      = fail_q;
        lock_user_d = lock_user_q;
        set_ok_d    = 1'b0;
        tmr_load    = 1'b0;
        tmr_val     = '0;
        tmr_dec     = 1'b0;

        // Timer-driven progress; overridden below by any accepted command.
        if (state_q == ST_GRANTED) begin
            if (tmr_zero) state_d = ST_IDLE;
            else          tmr_dec = 1'b1;
        end else if (state_q == ST_LOCKOUT) begin
            if (tmr_zero) begin
                state_d = ST_IDLE;
                for (int i = 0; i < NUM_USERS; i++) begin
                    if (lock_user_q == UW'(i)) fail_d[i] = '0;
                end
            end else begin
                tmr_dec = 1'b1;
            end
        end

        if (master_hit) begin
            for (int i = 0; i < NUM_USERS; i++) fail_d[i] = '0;
            state_d  = ST_GRANTED;
            tmr_load = 1'b1;
            tmr_val  = ACCESS_LD;
        end else if (cmd_ok && pw_match) begin
            for (int i = 0; i < NUM_USERS; i++) begin
                if (user_i == UW'(i)) begin
                    fail_d[i] = '0;
                    if (set_mode_i) pass_d[i] = new_pw_i;
                end
            end
            if (set_mode_i) begin
                set_ok_d = 1'b1;
            end else begin
                state_d  = ST_GRANTED;
                tmr_load = 1'b1;
                tmr_val  = ACCESS_LD;
            end
        end else if (cmd_ok) begin
            state_d = ST_IDLE;
            for (int i = 0; i < NUM_USERS; i++) begin
                if (user_i == UW'(i)) fail_d[i] = fail_inc;
            end
            if (user_valid && (fail_inc == FAIL_MAX)) begin
                state_d     = ST_LOCKOUT;
                tmr_load    = 1'b1;
                tmr_val     = LOCK_LD;
                lock_user_d = user_i;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_USERS; i++) begin
                pass_q[i] <= DEFAULT_PW[i*PW_W +: PW_W];
                fail_q[i] <= '0;
            end
            state_q     <= ST_IDLE;
            lock_user_q <= '0;
            access_q    <= 1'b0;
            alarm_q     <= 1'b0;
            locked_q    <= 1'b0;
            set_ok_q    <= 1'b0;
        end else begin
            pass_q      <= pass_d;
            fail_q      <= fail_d;
            state_q     <= state_d;
            lock_user_q <= lock_user_d;
            access_q    <= (state_d == ST_GRANTED);
            alarm_q     <= (state_d == ST_LOCKOUT);
            locked_q    <= (state_d == ST_LOCKOUT);
            set_ok_q    <= set_ok_d;
        end
    end

    assign access_o = access_q;
    assign alarm_o  = alarm_q;
    assign locked_o = locked_q;
    assign set_ok_o = set_ok_q;

endmodule

// File: tb/tb_locker_ctrl.sv
// Directed testbench for locker_ctrl with hand-computed expectations.
module tb_locker_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        enter;
    logic        set_mode;
    logic [1:0]  user;
    logic [11:0] pw_in;
    logic [11:0] new_pw;
    logic        access;
    logic        alarm;
    logic        locked;
    logic [1:0]  fail_cnt;
    logic        set_ok;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    locker_ctrl #(
        .MASTER_PW (12'hABC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enter_i    (enter),
        .set_mode_i (set_mode),
        .user_i     (user),
        .pw_in_i    (pw_in),
        .new_pw_i   (new_pw),
        .access_o   (access),
        .alarm_o    (alarm),
        .locked_o   (locked),
        .fail_cnt_o (fail_cnt),
        .set_ok_o   (set_ok)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic submit(input logic sm, input logic [1:0] u, input logic [11:0] pw, input logic [11:0] npw);
        @(negedge clk);
        set_mode = sm;
        user     = u;
        pw_in    = pw;
        new_pw   = npw;
        enter    = 1'b1;
        @(posedge clk);
        #1;
        enter = 1'b0;
    endtask

    task automatic select_user(input logic [1:0] u);
        @(negedge clk);
        user = u;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        enter = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_unlock();
        for (int n = 0; n < 1100 && locked; n++) tick(1);
        chk("unlock_timeout", locked, 0);
    endtask

    initial begin
        reset    = 1'b1;
        enter    = 1'b0;
        set_mode = 1'b0;
        user     = 2'd0;
        pw_in    = '0;
        new_pw   = '0;
        tick(3);
        chk("rst_access", access, 0);
        chk("rst_alarm", alarm, 0);
        chk("rst_locked", locked, 0);
        chk("rst_set_ok", set_ok, 0);
        chk("rst_fail", fail_cnt, 0);
        @(negedge clk);
        reset = 1'b0;

        // Test 1: grant window of 256 cycles
        submit(1'b0, 2'd1, 12'h0AA, 12'h000);
        chk("t1_grant", access, 1);
        tick(254);
        chk("t1_hold254", access, 1);
        tick(1);
        chk("t1_hold255", access, 1);
        tick(1);
        chk("t1_drop", access, 0);

        // Test 2: lockout after three failures, lasting 1024 cycles
        submit(1'b0, 2'd2, 12'h111, 12'h000);
        chk("t2_fail1", fail_cnt, 1);
        submit(1'b0, 2'd2, 12'h111, 12'h000);
        chk("t2_fail2", fail_cnt, 2);
        chk("t2_nolock", locked, 0);
        submit(1'b0, 2'd2, 12'h111, 12'h000);
        chk("t2_locked", locked, 1);
        chk("t2_alarm", alarm, 1);
        chk("t2_fail3", fail_cnt, 3);
        submit(1'b0, 2'd2, 12'hECE, 12'h000);
        chk("t2_ign_chk", access, 0);
        submit(1'b1, 2'd2, 12'hECE, 12'h777);
        chk("t2_ign_set", set_ok, 0);
        tick(1021);
        chk("t2_lock_last", locked, 1);
        chk("t2_alarm_last", alarm, 1);
        tick(1);
        chk("t2_unlock", locked, 0);
        chk("t2_alarm_off", alarm, 0);
        chk("t2_fail_clr", fail_cnt, 0);
        submit(1'b0, 2'd2, 12'hECE, 12'h000);
        chk("t2_pw_kept", access, 1);

        // Test 3: reprogram user 3
        do_reset();
        submit(1'b1, 2'd3, 12'h999, 12'h123);
        chk("t3_set_ok", set_ok, 1);
        chk("t3_no_access", access, 0);
        tick(1);
        chk("t3_set_pulse", set_ok, 0);
        submit(1'b0, 2'd3, 12'h999, 12'h000);
        chk("t3_old_rej", access, 0);
        chk("t3_old_fail", fail_cnt, 1);
        submit(1'b0, 2'd3, 12'h123, 12'h000);
        chk("t3_new_ok", access, 1);
        chk("t3_fail_clr", fail_cnt, 0);

        // Test 5: failure ends window; counters are per user
        submit(1'b0, 2'd1, 12'h111, 12'h000);
        chk("t5_drop", access, 0);
        chk("t5_u1_fail", fail_cnt, 1);
        submit(1'b0, 2'd0, 12'h111, 12'h000);
        submit(1'b0, 2'd0, 12'h111, 12'h000);
        chk("t5_u0_fail", fail_cnt, 2);
        chk("t5_nolock", locked, 0);
        select_user(2'd1);
        chk("t5_u1_kept", fail_cnt, 1);

        // Reset mid-window restores default passwords
        submit(1'b0, 2'd3, 12'h123, 12'h000);
        chk("rst2_grant", access, 1);
        do_reset();
        #1;
        chk("rst2_access", access, 0);
        select_user(2'd0);
        chk("rst2_fail", fail_cnt, 0);
        submit(1'b0, 2'd3, 12'h999, 12'h000);
        chk("rst2_default", access, 1);

        // Test 4: failed sets count toward lockout, password unchanged
        submit(1'b1, 2'd0, 12'h111, 12'h555);
        chk("t4_set_rej", set_ok, 0);
        chk("t4_drop", access, 0);
        chk("t4_fail1", fail_cnt, 1);
        submit(1'b1, 2'd0, 12'h111, 12'h555);
        chk("t4_fail2", fail_cnt, 2);
        submit(1'b0, 2'd0, 12'h111, 12'h000);
        chk("t4_locked", locked, 1);
        chk("t4_access", access, 0);
        wait_unlock();
        chk("t4_fail_clr", fail_cnt, 0);
        submit(1'b0, 2'd0, 12'hF2A, 12'h000);
        chk("t4_pw_kept", access, 1);
        submit(1'b0, 2'd0, 12'h555, 12'h000);
        chk("t4_new_rej", access, 0);

`ifdef LOCKER_MASTER_KEY_EN
        // Test 6: master key clears lockout
        do_reset();
        submit(1'b0, 2'd1, 12'h111, 12'h000);
        submit(1'b0, 2'd2, 12'h111, 12'h000);
        submit(1'b0, 2'd2, 12'h111, 12'h000);
        submit(1'b0, 2'd2, 12'h111, 12'h000);
        chk("t6_locked", locked, 1);
        submit(1'b0, 2'd0, 12'hABC, 12'h000);
        chk("t6_unlock", locked, 0);
        chk("t6_alarm", alarm, 0);
        chk("t6_access", access, 1);
        for (int u = 0; u < 4; u++) begin
            select_user(2'(u));
            chk("t6_fail_clr", fail_cnt, 0);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
